// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg
// Shared definitions for the data-RAM arbiter and its round-robin picker:
//   AW_DEF / DW_DEF : default word-address and data widths
//   clog2()         : core-id width helper (never narrower than 1 bit)
//   lock_state_e    : bus-lock FSM states, used when ARB_LOCK_EN is defined
package dram_arb_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

endpackage

// File: rtl/dram_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin priority picker.
// Ports:
//   elig       in  N_CORES  eligible requesters
//   ptr        in  IW       highest-priority index this cycle
//   win_onehot out N_CORES  one-hot winner, zero when nothing is eligible
//   win_idx    out IW       winner index, zero when nothing is eligible
module rr_pick
  import dram_arb_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int IW      = clog2(N_CORES)
) (
  input  logic [N_CORES-1:0] elig,
  input  logic [IW-1:0]      ptr,
  output logic [N_CORES-1:0] win_onehot,
  output logic [IW-1:0]      win_idx
);

  localparam logic [IW:0] NC = (IW+1)'(N_CORES);

  logic [IW:0] cand;
  logic        found;

  // Walk upward from ptr; one extra bit lets ptr+k be wrapped with a
  // single subtraction, which also works for non-power-of-two core counts.
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    found      = 1'b0;
    cand       = '0;
    for (int k = 0; k < N_CORES; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= NC) cand = cand - NC;
      if (!found && elig[cand[IW-1:0]]) begin
        found                       = 1'b1;
        win_idx                     = cand[IW-1:0];
        win_onehot[cand[IW-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter
// Round-robin arbiter letting N_CORES core data ports share one single-port
// synchronous RAM. Read data returns three cycles after the request cycle,
// tagged by a one-hot rvalid; the grant itself acknowledges a write.
// Optional feature: define ARB_LOCK_EN to add a per-core lock input that lets
// one core hold the RAM exclusively across consecutive accesses.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   lock   (ARB_LOCK_EN only)  per-core lock request, sampled with req
//   req, we, addr, wdata       per-core request bundle (addr/wdata packed)
//   gnt, rvalid, rdata         per-core grant / read-valid, broadcast read data
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata       single-port RAM interface
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef ARB_LOCK_EN
  input  logic [N_CORES-1:0]    lock,
`endif
  input  logic [N_CORES-1:0]    req,
  input  logic [N_CORES-1:0]    we,
  input  logic [N_CORES*AW-1:0] addr,
  input  logic [N_CORES*DW-1:0] wdata,
  output logic [N_CORES-1:0]    gnt,
  output logic [N_CORES-1:0]    rvalid,
  output logic [DW-1:0]         rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  input  logic [DW-1:0]         mem_rdata
);

  localparam int IW = clog2(N_CORES);
  localparam logic [IW-1:0] LAST_ID = IW'(N_CORES - 1);

  logic [N_CORES-1:0] gnt_q, gnt_d;
  logic [N_CORES-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic [DW-1:0]      mem_wdata_q, mem_wdata_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               s1_valid_q, s1_valid_d;
  logic [IW-1:0]      s1_id_q, s1_id_d;
  logic               s2_valid_q, s2_valid_d;
  logic [IW-1:0]      s2_id_q, s2_id_d;

  logic [N_CORES-1:0] elig;
  logic [N_CORES-1:0] win_onehot;
  logic [IW-1:0]      win_idx;
  logic               win_valid;
  logic               ptr_adv;

`ifdef ARB_LOCK_EN
  lock_state_e        state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [N_CORES-1:0] owner_mask;
`endif

  // A core is never eligible in the cycle its gnt is high, so a core that
  // holds req is served at most every other cycle. While locked, only the
  // owner may win and the pointer stays put so fairness resumes on unlock.
  always_comb begin
    elig    = req & ~gnt_q;
    ptr_adv = 1'b1;
`ifdef ARB_LOCK_EN
    owner_mask          = '0;
    owner_mask[owner_q] = 1'b1;
    if (state_q == LOCK_HELD) begin
      elig    = elig & owner_mask;
      ptr_adv = 1'b0;
    end
`endif
  end

  rr_pick #(
    .N_CORES (N_CORES),
    .IW      (IW)
  ) u_rr_pick (
    .elig       (elig),
    .ptr        (rr_ptr_q),
    .win_onehot (win_onehot),
    .win_idx    (win_idx)
  );

  assign win_valid = |win_onehot;

  // Grant/RAM command stage plus the two-deep read-tag pipeline. Stage 1
  // lines up with the RAM access cycle, stage 2 with the cycle mem_rdata is
  // valid; rdata is captured from stage 2 so it appears with rvalid.
  always_comb begin
    gnt_d       = win_onehot;
    mem_en_d    = win_valid;
    mem_we_d    = win_valid & we[win_idx];
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rr_ptr_d    = rr_ptr_q;
    if (win_valid) begin
      mem_addr_d  = addr[win_idx*AW +: AW];
      mem_wdata_d = wdata[win_idx*DW +: DW];
      if (ptr_adv) begin
        rr_ptr_d = (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;
      end
    end

    s1_valid_d = win_valid & ~we[win_idx];
    s1_id_d    = win_idx;
    s2_valid_d = s1_valid_q;
    s2_id_d    = s1_id_q;

    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (s2_valid_q) begin
      rvalid_d[s2_id_q] = 1'b1;
      rdata_d           = mem_rdata;
    end
  end

`ifdef ARB_LOCK_EN
  // Lock is taken by a granted access with lock=1 and released by the
  // owner's next granted access with lock=0 (that access still happens).
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      LOCK_IDLE: begin
        if (win_valid && lock[win_idx]) begin
          state_d = LOCK_HELD;
          owner_d = win_idx;
        end
      end
      LOCK_HELD: begin
        if (win_valid && !lock[win_idx]) state_d = LOCK_IDLE;
      end
      default: state_d = LOCK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOCK_IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rr_ptr_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_id_q     <= '0;
    end else begin
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rr_ptr_q    <= rr_ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s2_valid_q  <= s2_valid_d;
      s2_id_q     <= s2_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter
// Directed bench for dram_arbiter with a write-first single-port RAM model.
// Define ARB_LOCK_EN on both bench and design to include the lock scenario.
module tb_dram_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
`ifdef ARB_LOCK_EN
  logic [N-1:0]    lock;
`endif

  logic [DW-1:0]   ram [0:(1<<AW)-1];

  int testsRun;
  int testsFailed;

  dram_arbiter #(
    .N_CORES (N),
    .AW      (AW),
    .DW      (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef ARB_LOCK_EN
    .lock      (lock),
`endif
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first synchronous single-port RAM
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        mem_rdata     <= mem_wdata;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int core, input logic r, input logic w,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[core]            = r;
    we[core]             = w;
    addr[core*AW +: AW]  = a;
    wdata[core*DW +: DW] = d;
  endtask

  // Advance past the next rising edge; registered outputs are then stable.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
`ifdef ARB_LOCK_EN
    lock  = '0;
`endif
  endtask

  task automatic resetDut();
    clearInputs();
    rst_n = 1'b0;
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    for (int i = 0; i < (1 << AW); i++) ram[i] <= 32'h1000_0000 + i;
    ram[5] <= 32'h0000_00AA;
    rst_n = 1'b0;
    clearInputs();
    #2;

    // Reset state
    resetDut();
    checkOutput("rst_gnt", 64'(gnt), 64'h0);
    checkOutput("rst_rvalid", 64'(rvalid), 64'h0);
    checkOutput("rst_mem_en", 64'(mem_en), 64'h0);
    checkOutput("rst_mem_we", 64'(mem_we), 64'h0);
    checkOutput("rst_rdata", 64'(rdata), 64'h0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'h0);

    // Single read by core0 from 0x005
    applyStimulus(0, 1'b1, 1'b0, 12'h005, 32'h0);
    stepCycle();
    checkOutput("rd_gnt", 64'(gnt), 64'h1);
    checkOutput("rd_mem_en", 64'(mem_en), 64'h1);
    checkOutput("rd_mem_we", 64'(mem_we), 64'h0);
    checkOutput("rd_mem_addr", 64'(mem_addr), 64'h005);
    applyStimulus(0, 1'b0, 1'b0, 12'h005, 32'h0);
    stepCycle();
    checkOutput("rd_rvalid_early", 64'(rvalid), 64'h0);
    stepCycle();
    checkOutput("rd_rvalid", 64'(rvalid), 64'h1);
    checkOutput("rd_rdata", 64'(rdata), 64'hAA);
    stepCycle();
    checkOutput("rd_rvalid_pulse", 64'(rvalid), 64'h0);
    checkOutput("rd_rdata_hold", 64'(rdata), 64'hAA);

    // All four cores read, holding req
    resetDut();
    for (int c = 0; c < N; c++) applyStimulus(c, 1'b1, 1'b0, 12'(12'h010 + c), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      stepCycle();
      checkOutput($sformatf("rr_gnt_%0d", k), 64'(gnt), 64'(1 << ((k - 1) % N)));
      if (k >= 3) begin
        checkOutput($sformatf("rr_rvalid_%0d", k), 64'(rvalid), 64'(1 << ((k - 3) % N)));
        checkOutput($sformatf("rr_rdata_%0d", k), 64'(rdata),
                    64'(32'h1000_0010 + ((k - 3) % N)));
      end else begin
        checkOutput($sformatf("rr_rvalid_%0d", k), 64'(rvalid), 64'h0);
      end
    end
    clearInputs();
    repeat (4) stepCycle();

    // Core2 writes 0x0FF, core3 reads it back the next cycle
    resetDut();
    applyStimulus(2, 1'b1, 1'b1, 12'h0FF, 32'hDEAD_BEEF);
    stepCycle();
    checkOutput("wr_gnt", 64'(gnt), 64'h4);
    checkOutput("wr_mem_we", 64'(mem_we), 64'h1);
    checkOutput("wr_mem_addr", 64'(mem_addr), 64'h0FF);
    checkOutput("wr_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    applyStimulus(2, 1'b0, 1'b0, 12'h0, 32'h0);
    applyStimulus(3, 1'b1, 1'b0, 12'h0FF, 32'h0);
    stepCycle();
    checkOutput("wr_rd_gnt", 64'(gnt), 64'h8);
    checkOutput("wr_rd_mem_we", 64'(mem_we), 64'h0);
    checkOutput("wr_rvalid_t2", 64'(rvalid), 64'h0);
    applyStimulus(3, 1'b0, 1'b0, 12'h0, 32'h0);
    stepCycle();
    checkOutput("wr_rvalid_t3", 64'(rvalid), 64'h0);
    stepCycle();
    checkOutput("wr_rd_rvalid", 64'(rvalid), 64'h8);
    checkOutput("wr_rd_rdata", 64'(rdata), 64'hDEAD_BEEF);

    // Core1 alone holding req: grant every other cycle
    resetDut();
    applyStimulus(1, 1'b1, 1'b0, 12'h020, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      stepCycle();
      checkOutput($sformatf("solo_gnt_%0d", k), 64'(gnt), (k % 2 == 1) ? 64'h2 : 64'h0);
    end
    clearInputs();
    repeat (4) stepCycle();

    // Reset while a read is in flight
    resetDut();
    applyStimulus(0, 1'b1, 1'b0, 12'h005, 32'h0);
    stepCycle();
    checkOutput("mid_gnt", 64'(gnt), 64'h1);
    clearInputs();
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    checkOutput("mid_rst_gnt", 64'(gnt), 64'h0);
    checkOutput("mid_rst_mem_en", 64'(mem_en), 64'h0);
    checkOutput("mid_rst_rdata", 64'(rdata), 64'h0);
    checkOutput("mid_rst_rvalid", 64'(rvalid), 64'h0);
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkOutput($sformatf("mid_no_rvalid_%0d", k), 64'(rvalid), 64'h0);
    end
    for (int c = 0; c < N; c++) applyStimulus(c, 1'b1, 1'b0, 12'h030, 32'h0);
    stepCycle();
    checkOutput("mid_next_gnt", 64'(gnt), 64'h1);
    clearInputs();
    repeat (4) stepCycle();

`ifdef ARB_LOCK_EN
    // Core0 locks with a read, then unlocks with a write before others run
    resetDut();
    for (int c = 0; c < N; c++) applyStimulus(c, 1'b1, 1'b0, 12'h040, 32'h0);
    lock = 4'b0001;
    stepCycle();
    checkOutput("lk_gnt_lock", 64'(gnt), 64'h1);
    applyStimulus(0, 1'b1, 1'b1, 12'h041, 32'h1234_5678);
    lock = 4'b0000;
    stepCycle();
    checkOutput("lk_gnt_wait", 64'(gnt), 64'h0);
    stepCycle();
    checkOutput("lk_gnt_unlock", 64'(gnt), 64'h1);
    checkOutput("lk_mem_we", 64'(mem_we), 64'h1);
    applyStimulus(0, 1'b0, 1'b0, 12'h0, 32'h0);
    stepCycle();
    checkOutput("lk_gnt_next", 64'(gnt), 64'h2);
    clearInputs();
    repeat (4) stepCycle();
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
